// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: 4-digit common-anode 7-seg scanner with blanking gap and frame-aligned double buffer (option: SEG_LEADING_ZERO_BLANK_EN)
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] last = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] blk  = CW'(BLANK_CYCLES);
  localparam logic [6:0] hex_lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    dig, dig_n;
  logic [15:0]   shadow, shadow_n, pending;
  logic [3:0]    shadow_dp, shadow_dp_n, pending_dp;
  logic          pend_valid;
  logic          wrap, sup, lit;
  logic [3:0]    nib;
  // next scan position and buffer state; outputs are registered from these so they line up with the cycle they describe
  always_comb begin
    wrap        = cnt == last;
    cnt_n       = wrap ? '0 : cnt + 1'b1;
    dig_n       = wrap ? dig + 2'd1 : dig;
    shadow_n    = frame_done ? (load ? value : pend_valid ? pending : shadow) : shadow;
    shadow_dp_n = frame_done ? (load ? dp_in : pend_valid ? pending_dp : shadow_dp) : shadow_dp;
    nib         = shadow_n[{dig_n, 2'b00} +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    sup         = (dig_n != 2'd0) && ((shadow_n >> {dig_n, 2'b00}) == 16'd0);
`else
    sup         = 1'b0;
`endif
    lit         = (cnt_n >= blk) && digit_en[dig_n] && !sup;
  end
  // scan counters, double buffer and registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      dig        <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= '0;
      pending_dp <= '0;
      pend_valid <= 1'b0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      dig        <= dig_n;
      shadow     <= shadow_n;
      shadow_dp  <= shadow_dp_n;
      if (load && !frame_done) begin
        pending    <= value;
        pending_dp <= dp_in;
      end
      pend_valid <= (load && !frame_done) || (pend_valid && !frame_done);
      an         <= lit ? ~(4'b0001 << dig_n) : 4'hF;
      seg        <= lit ? hex_lut[nib] : 7'h7F;
      dp         <= lit ? ~shadow_dp_n[dig_n] : 1'b1;
      frame_done <= (dig_n == 2'd3) && (cnt_n == last);
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scoreboarded random/directed check of the scan driver against a cycle-index reference model
module tb_seven_seg_scan_driver;
  localparam int R = 8;
  localparam int B = 2;
  localparam int F = 4 * R;
  logic clk = 0, reset = 1, load = 0;
  logic [15:0] value = '0;
  logic [3:0] dp_in = '0, digit_en = 4'hF;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, frame_done;
  seven_seg_scan_driver #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [6:0] hexd [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int mc = 0;
  logic [15:0] disp = '0, pend = '0;
  logic [3:0] ddp = '0, pdp = '0;
  logic pv = 0;
  function automatic logic suppressed(int s);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    return s > 0 && (disp >> (4 * s)) == 16'd0;
`else
    return 1'b0;
`endif
  endfunction
  function automatic exp_t model_out(logic [3:0] en);
    exp_t e;
    int pos, s;
    logic on;
    pos = mc % R;
    s = (mc / R) % 4;
    on = pos >= B && en[s] && !suppressed(s);
    e.cyc = mc;
    e.an = on ? ~(4'b0001 << s) : 4'hF;
    e.seg = on ? hexd[disp[4*s +: 4]] : 7'h7F;
    e.dp = on ? ~ddp[s] : 1'b1;
    e.fd = (mc % F) == F - 1;
    return e;
  endfunction
  task automatic cyc(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] dpi, input logic [3:0] en);
    exp_t e;
    reset = r; load = ld; value = v; dp_in = dpi; digit_en = en;
    if (r) begin
      mc = 0; disp = '0; ddp = '0; pv = 0;
      e.cyc = -1; e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
    end else begin
      if (mc % F == F - 1) begin
        if (ld) begin disp = v; ddp = dpi; end
        else if (pv) begin disp = pend; ddp = pdp; end
        pv = 0;
      end else if (ld) begin
        pend = v; pdp = dpi; pv = 1;
      end
      mc++;
      e = model_out(en);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n, input int l1, input logic [15:0] v1, input int l2, input logic [15:0] v2,
                     input logic [3:0] en, input logic [3:0] dpi, input int rst_at);
    cyc(1, 0, 16'h0, dpi, en);
    cyc(1, 0, 16'h0, dpi, en);
    for (int c = 0; c < n; c++)
      cyc(c == rst_at, c == l1 || c == l2, c == l2 ? v2 : v1, dpi, en);
  endtask
  function automatic void chk(string n, logic [31:0] got, logic [31:0] want, int c);
    checks++;
    if (got !== want) begin
      errors++;
      if (errors <= 30) $display("FAIL %s cycle=%0d got=%0h expected=%0h", n, c, got, want);
    end
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an", 32'(an), 32'(e.an), e.cyc);
      chk("seg", 32'(seg), 32'(e.seg), e.cyc);
      chk("dp", 32'(dp), 32'(e.dp), e.cyc);
      chk("frame_done", 32'(frame_done), 32'(e.fd), e.cyc);
    end
  end
  initial begin
    logic ld, r;
    logic [15:0] v;
    logic [3:0] en, dpi;
    run(70, 3, 16'h1234, -1, 16'h0, 4'hF, 4'b1010, -1);
    run(100, 31, 16'hABCD, -1, 16'h0, 4'hF, 4'b0000, -1);
    run(70, 5, 16'h1111, 20, 16'h2222, 4'hF, 4'b0110, -1);
    run(70, 3, 16'h1234, -1, 16'h0, 4'b0101, 4'b0001, -1);
    run(70, 3, 16'h0070, -1, 16'h0, 4'hF, 4'b1111, -1);
    run(90, 3, 16'h5678, 40, 16'h9999, 4'hF, 4'b0011, 45);
    en = 4'hF;
    cyc(1, 0, 16'h0, 4'h0, en);
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 399) == 0;
      ld = $urandom_range(0, 9) == 0;
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = v & 16'h00FF;
        1: v = v & 16'h000F;
        default: ;
      endcase
      dpi = 4'($urandom);
      if ($urandom_range(0, 49) == 0) en = 4'($urandom);
      cyc(r, ld, v, dpi, en);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0, mc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed scan driver for the board's 4-digit common-anode 7-segment display. Holds a double-buffered 16-bit hex value and walks through the four digits with a programmable refresh period and an all-off blanking gap. During each digit slot it drives the active-low anode select and hex-decoded segment pattern. New display data is committed only at frame boundaries, so the display never shows a mix of old and new digits. Sits between game/score logic and the display pins.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV (0 allowed).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value  in  16  hex nibbles; [3:0] is digit 0 (far right), [15:12] is digit 3 (far left).
- dp_in  in  4  decimal point request per digit, 1 = on.
- digit_en  in  4  per-digit enable; sampled live, not buffered.
- load  in  1  1-cycle strobe that captures value/dp_in into the pending buffer.
- an  out  4  anode select, active low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.
- frame_done  out  1  1-cycle pulse on the last cycle of digit 3's slot.

## Operation
- Counter cnt runs 0..REFRESH_DIV-1 and wraps. Digit index dig (2 bits) advances 0→1→2→3→0 on each cnt wrap.
- Phase BLANK while cnt < BLANK_CYCLES; phase ON otherwise.
- In BLANK: an=4'b1111, seg=7'h7F, dp=1.
- In ON, when digit_en[dig] is set and the digit is not suppressed:
  - an = 1110 / 1101 / 1011 / 0111 for dig = 0 / 1 / 2 / 3.
  - seg = hex decode of shadow nibble[dig]; dp = ~shadow_dp[dig].
- In ON, when the digit is disabled or suppressed: outputs stay as in BLANK.
- Hex decode (gfedcba, active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Buffering:
  - load writes value/dp_in into the pending registers and sets pend_valid. With several loads in one frame, the last one wins.
  - On the edge after frame_done: shadow ← pending if pend_valid, then pend_valid clears.
  - If load coincides with frame_done, that cycle's value/dp_in go straight to shadow.
- Reset values: an=4'hF, seg=7'h7F, dp=1, frame_done=0, cnt=0, dig=0, shadow=0, shadow_dp=0, pend_valid=0.
- Reset mid-frame aborts the scan, discards pending data and clears shadow.

## Timing
- All outputs are registered. Each output reflects the cnt/dig/shadow state of the same cycle, i.e. the value computed at the preceding edge.
- Cycle 0 is the first cycle after reset is released.
- Digit d is lit during cycles d·REFRESH_DIV+BLANK_CYCLES through (d+1)·REFRESH_DIV−1.
- Frame length is 4·REFRESH_DIV cycles. frame_done is high on cycle 4·REFRESH_DIV−1 of every frame.
- Load-to-display latency: the first digit-0 ON cycle of the frame following the next frame_done.
- An anode-change transition never activates two anodes at once; with BLANK_CYCLES=0 the anodes switch directly in one edge.
- cnt width is $clog2(REFRESH_DIV); no other arithmetic.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined: digit k (k=3,2,1) is suppressed when shadow nibbles k..3 are all zero. Digit 0 is never suppressed. Suppressed digits keep their dp off as well.
- Not defined: all enabled digits always display, including leading zeros.

## Test plan
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, then load value=16'h1234 at cycle 3 -> frame 0 digit 0 seg=7'h40; from cycle 34 an=1110, seg=7'b0011001 (4); digit 3 at cycles 58–63 shows seg=7'b1111001 (1).
- Free run -> an=1111 on cycles 0–1, 1110 on 2–7, 1111 on 8–9, 1101 on 10–15; frame_done high only on cycles 31, 63, 95.
- load=1 with value=16'hABCD exactly on cycle 31 -> cycle 34 shows seg=7'b0100001 (d). Loads of 16'h1111 at cycle 5 and 16'h2222 at cycle 20 -> frame 1 shows 2 on every digit.
- digit_en=4'b0101, dp_in=4'b0001 -> digits 1 and 3 keep an=1111 for their whole slot; digit 0 shows dp=0.
- value=16'h0070 -> with SEG_LEADING_ZERO_BLANK_EN, digits 3 and 2 stay an=1111, digit 1 shows 7 and digit 0 shows 0; without the macro, all four digits light.
- Assert reset at cycle 45 with load pending -> outputs return to reset values the next cycle; the scan restarts at digit 0, cnt=0, and the display shows zeros.
